// File: rtl/mem_bus_arbiter.sv
// Shares the core-side memory port between fetch reads, store-buffer reads and
// store-buffer writes: two-state grant FSM, fixed priority with write anti-starvation.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_WIDTH   = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] if_arb_read_addr,
  input  logic                  if_arb_read_req,
  output logic                  arb_if_read_ack,
  output logic [DATA_WIDTH-1:0] arb_if_data,
  input  logic [ADDR_WIDTH-1:0] stbuf_bus_read_addr,
  input  logic [SIZE_WIDTH-1:0] stbuf_bus_read_size,
  input  logic                  stbuf_bus_read_req,
  output logic                  bus_stbuf_read_ack,
  output logic [DATA_WIDTH-1:0] bus_stbuf_data,
  input  logic [ADDR_WIDTH-1:0] stbuf_bus_write_addr,
  input  logic [SIZE_WIDTH-1:0] stbuf_bus_write_size,
  input  logic [DATA_WIDTH-1:0] stbuf_bus_data,
  input  logic                  stbuf_bus_write_req,
  output logic                  bus_stbuf_write_ack,
  input  logic                  flush,
  output logic                  arb_mem_req,
  output logic                  arb_mem_we,
  output logic [ADDR_WIDTH-1:0] arb_mem_addr,
  output logic [SIZE_WIDTH-1:0] arb_mem_size,
  output logic [DATA_WIDTH-1:0] arb_mem_wdata,
  input  logic                  mem_arb_ack,
  input  logic [DATA_WIDTH-1:0] mem_arb_rdata,
  output logic                  arb_busy,
  output logic [1:0]            arb_grant_id
);

  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_RD    = 2'd2;
  localparam logic [1:0] OWN_WR    = 2'd3;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            owner_reg;
  logic [1:0]            winner;
  logic                  drop_reg;
  logic [CNT_WIDTH-1:0]  starve_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [SIZE_WIDTH-1:0] size_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  we_reg;
  logic                  starved;
  logic                  owner_is_read;
  logic                  done;
  logic                  suppress;
  logic [DATA_WIDTH-1:0] rd_mask;

  assign starved       = (starve_reg >= STARVE_MAX);
  assign owner_is_read = (owner_reg == OWN_FETCH) || (owner_reg == OWN_RD);

  // Reads are ineligible during flush; a starved write overrides normal priority.
  always_comb begin
    winner = OWN_NONE;
    if (starved && stbuf_bus_write_req)
      winner = OWN_WR;
    else if (stbuf_bus_read_req && !flush)
      winner = OWN_RD;
    else if (if_arb_read_req && !flush)
      winner = OWN_FETCH;
    else if (stbuf_bus_write_req)
      winner = OWN_WR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (winner != OWN_NONE) state_next = BUSY;
      BUSY: if (mem_arb_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store-buffer reads return only the requested low-order bytes.
  always_comb begin
    rd_mask = {DATA_WIDTH{1'b1}};
    if (size_reg == SIZE_WIDTH'(1))
      rd_mask = DATA_WIDTH'(16'h00FF);
    else if (size_reg == SIZE_WIDTH'(2))
      rd_mask = DATA_WIDTH'(16'hFFFF);
  end

  always_comb begin
    arb_mem_req         = (state_reg == BUSY);
    arb_busy            = (state_reg == BUSY);
    arb_grant_id        = owner_reg;
    done                = (state_reg == BUSY) && mem_arb_ack;
    suppress            = owner_is_read && (drop_reg || flush);
    arb_if_read_ack     = done && !suppress && (owner_reg == OWN_FETCH);
    bus_stbuf_read_ack  = done && !suppress && (owner_reg == OWN_RD);
    bus_stbuf_write_ack = done && (owner_reg == OWN_WR);
    arb_if_data         = arb_if_read_ack ? mem_arb_rdata : '0;
    bus_stbuf_data      = bus_stbuf_read_ack ? (mem_arb_rdata & rd_mask) : '0;
  end

  assign arb_mem_we    = we_reg;
  assign arb_mem_addr  = addr_reg;
  assign arb_mem_size  = size_reg;
  assign arb_mem_wdata = wdata_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg <= OWN_NONE;
      drop_reg  <= 1'b0;
      addr_reg  <= '0;
      size_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
    end else if (state_reg == IDLE) begin
      owner_reg <= winner;
      case (winner)
        OWN_FETCH: begin
          addr_reg  <= if_arb_read_addr;
          size_reg  <= SIZE_WIDTH'(4);
          wdata_reg <= '0;
          we_reg    <= 1'b0;
        end
        OWN_RD: begin
          addr_reg  <= stbuf_bus_read_addr;
          size_reg  <= stbuf_bus_read_size;
          wdata_reg <= '0;
          we_reg    <= 1'b0;
        end
        OWN_WR: begin
          addr_reg  <= stbuf_bus_write_addr;
          size_reg  <= stbuf_bus_write_size;
          wdata_reg <= stbuf_bus_data;
          we_reg    <= 1'b1;
        end
        default: ;
      endcase
    end else if (mem_arb_ack) begin
      owner_reg <= OWN_NONE;
      drop_reg  <= 1'b0;
    end else if (flush && owner_is_read) begin
      drop_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_reg <= '0;
    else if (state_reg == IDLE) begin
      if (winner == OWN_WR)
        starve_reg <= '0;
      else if (stbuf_bus_write_req && !starved)
        starve_reg <= starve_reg + 1'b1;
    end else if (stbuf_bus_write_req && owner_reg != OWN_WR && !starved)
      starve_reg <= starve_reg + 1'b1;
  end

endmodule
